// File: rtl/decode_stage.sv
// RV64I decode stage: register-file read, immediate/control decode, load-use bubbles, ID/EX register.
// Optional same-cycle write-back bypass is enabled by defining DECODE_WB_BYPASS_EN.
module decode_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_ready,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    input  logic [XLEN-1:0]  readData1,
    input  logic [XLEN-1:0]  readData2,
    input  logic             wb_regWrite,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1Data,
    output logic [XLEN-1:0]  ex_rs2Data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [6:0]       ex_opcode,
    output logic [2:0]       ex_funct3,
    output logic [6:0]       ex_funct7,
    output logic             ex_memRead,
    output logic             ex_memWrite,
    output logic             ex_regWrite,
    output logic [CNT_W-1:0] hazard_count
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1Data;
        logic [XLEN-1:0] rs2Data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            memRead;
        logic            memWrite;
        logic            regWrite;
    } idex_t;

    idex_t            r_idex;
    idex_t            w_dec;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       w_op;
    logic [4:0]       w_rd;
    logic [XLEN-1:0]  w_imm;
    logic [XLEN-1:0]  w_rs1Data;
    logic [XLEN-1:0]  w_rs2Data;
    logic             w_loaduse;

    assign w_op = if_instr[6:0];
    assign w_rd = if_instr[11:7];
    assign rs1  = if_instr[19:15];
    assign rs2  = if_instr[24:20];

    always_comb begin
        w_imm = '0;
        case (w_op)
            OP_IMM, OP_IMM32, OP_LOAD, OP_JALR:
                w_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            OP_STORE:
                w_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OP_BRANCH:
                w_imm = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                         if_instr[30:25], if_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
            OP_JAL:
                w_imm = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                         if_instr[20], if_instr[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

`ifdef DECODE_WB_BYPASS_EN
    assign w_rs1Data = (rs1 == 5'd0) ? '0 :
                       (wb_regWrite && wb_rd == rs1) ? wb_data : readData1;
    assign w_rs2Data = (rs2 == 5'd0) ? '0 :
                       (wb_regWrite && wb_rd == rs2) ? wb_data : readData2;
`else
    // Register file writes through, so the write-back port is not needed here.
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_regWrite, wb_rd, wb_data};
    assign w_rs1Data = (rs1 == 5'd0) ? '0 : readData1;
    assign w_rs2Data = (rs2 == 5'd0) ? '0 : readData2;
`endif

    always_comb begin
        w_dec          = '0;
        w_dec.valid    = if_valid;
        w_dec.pc       = if_pc;
        w_dec.rs1Data  = w_rs1Data;
        w_dec.rs2Data  = w_rs2Data;
        w_dec.imm      = w_imm;
        w_dec.rs1      = rs1;
        w_dec.rs2      = rs2;
        w_dec.rd       = w_rd;
        w_dec.opcode   = w_op;
        w_dec.funct3   = if_instr[14:12];
        w_dec.funct7   = if_instr[31:25];
        w_dec.memRead  = (w_op == OP_LOAD);
        w_dec.memWrite = (w_op == OP_STORE);
        w_dec.regWrite = (w_rd != 5'd0) &&
                         (w_op inside {OP_REG, OP_REG32, OP_IMM, OP_IMM32, OP_LOAD,
                                       OP_LUI, OP_AUIPC, OP_JAL, OP_JALR});
    end

    // Both sources are compared regardless of format; a false stall only costs a cycle.
    assign w_loaduse = if_valid && r_idex.valid && r_idex.memRead && (r_idex.rd != 5'd0) &&
                       (r_idex.rd == rs1 || r_idex.rd == rs2);
    assign id_ready  = ex_ready && !w_loaduse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idex <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            r_idex.valid <= 1'b0;
        end else if (!ex_ready) begin
            r_idex <= r_idex;
        end else if (w_loaduse) begin
            r_idex.valid <= 1'b0;
            if (r_cnt != {CNT_W{1'b1}})
                r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_idex <= w_dec;
        end
    end

    assign ex_valid     = r_idex.valid;
    assign ex_pc        = r_idex.pc;
    assign ex_rs1Data   = r_idex.rs1Data;
    assign ex_rs2Data   = r_idex.rs2Data;
    assign ex_imm       = r_idex.imm;
    assign ex_rs1       = r_idex.rs1;
    assign ex_rs2       = r_idex.rs2;
    assign ex_rd        = r_idex.rd;
    assign ex_opcode    = r_idex.opcode;
    assign ex_funct3    = r_idex.funct3;
    assign ex_funct7    = r_idex.funct7;
    assign ex_memRead   = r_idex.memRead;
    assign ex_memWrite  = r_idex.memWrite;
    assign ex_regWrite  = r_idex.regWrite;
    assign hazard_count = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic [4:0]  rs1, rs2;
    logic [63:0] readData1, readData2;
    logic        wb_regWrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_rs1Data, ex_rs2Data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_memRead, ex_memWrite, ex_regWrite;
    logic [31:0] hazard_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        mr, mw, rw;
    } exp_t;

    exp_t        m;
    logic [31:0] m_cnt;
    exp_t        dut;
    logic [63:0] rf [32];

    assign dut = {ex_valid, ex_pc, ex_rs1Data, ex_rs2Data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                  ex_opcode, ex_funct3, ex_funct7, ex_memRead, ex_memWrite, ex_regWrite};
    assign readData1 = rf[if_instr[19:15]];
    assign readData2 = rf[if_instr[24:20]];

    decode_stage dut_i (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .rs1(rs1), .rs2(rs2), .readData1(readData1), .readData2(readData2),
        .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1Data(ex_rs1Data),
        .ex_rs2Data(ex_rs2Data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_regWrite(ex_regWrite),
        .hazard_count(hazard_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] opnd(logic [4:0] idx);
        if (idx == 5'd0) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_regWrite && wb_rd == idx) return wb_data;
`endif
        return rf[idx];
    endfunction

    function automatic exp_t decode(logic v, logic [31:0] ins, logic [63:0] pc);
        exp_t e;
        logic [6:0] op;
        op     = ins[6:0];
        e.valid = v;
        e.pc   = pc;
        e.rs1  = ins[19:15];
        e.rs2  = ins[24:20];
        e.rd   = ins[11:7];
        e.op   = op;
        e.f3   = ins[14:12];
        e.f7   = ins[31:25];
        e.rs1d = opnd(e.rs1);
        e.rs2d = opnd(e.rs2);
        case (op)
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111:
                e.imm = longint'($signed(ins[31:20]));
            7'b0100011: e.imm = longint'($signed({ins[31:25], ins[11:7]}));
            7'b1100011: e.imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            7'b0110111, 7'b0010111: e.imm = longint'($signed({ins[31:12], 12'b0}));
            7'b1101111: e.imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default: e.imm = 64'd0;
        endcase
        e.mr = (op == 7'b0000011);
        e.mw = (op == 7'b0100011);
        e.rw = (e.rd != 0) && (op inside {7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011,
                7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111});
        return e;
    endfunction

    function automatic logic model_lu();
        return if_valid && m.valid && m.mr && (m.rd != 0) &&
               (m.rd == if_instr[19:15] || m.rd == if_instr[24:20]);
    endfunction

    task automatic drive(logic v, logic [31:0] ins, logic [63:0] pc, logic er, logic fl,
                         logic ww, logic [4:0] wr, logic [63:0] wd);
        if_valid = v; if_instr = ins; if_pc = pc; ex_ready = er; flush = fl;
        wb_regWrite = ww; wb_rd = wr; wb_data = wd;
        #1;
    endtask

    task automatic tick();
        logic lu;
        lu = model_lu();
        if (flush) m.valid = 1'b0;
        else if (!ex_ready) m = m;
        else if (lu) begin
            m.valid = 1'b0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else m = decode(if_valid, if_instr, if_pc);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m = '0;
        m_cnt = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        #2;
        checks++;
        if (dut !== exp_t'(0) || hazard_count !== 32'd0) begin
            errors++; $display("FAIL reset_regs got %h cnt %0d want 0", dut, hazard_count);
        end
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got %b want 1", id_ready); end
        ex_ready = 1'b0; #1;
        checks++;
        if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready_lo got %b want 0", id_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        m = '0; m_cnt = 0;
    endtask

    task automatic test_basic_decode();
        drive(1'b1, 32'h006281B3, 64'h1000, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        checks++;
        if (rs1 !== 5'd5 || rs2 !== 5'd6) begin
            errors++; $display("FAIL basic_rs got %0d/%0d want 5/6", rs1, rs2);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_rs1Data !== 64'd5 || ex_rs2Data !== 64'd6 ||
            ex_rd !== 5'd3 || ex_regWrite !== 1'b1) begin
            errors++; $display("FAIL basic_add got v%b %h %h rd%0d rw%b want v1 5 6 rd3 rw1",
                               ex_valid, ex_rs1Data, ex_rs2Data, ex_rd, ex_regWrite);
        end
        checks++;
        if (dut !== m) begin errors++; $display("FAIL basic_model got %h want %h", dut, m); end
    endtask

    task automatic test_wb_bypass();
        logic [63:0] want;
`ifdef DECODE_WB_BYPASS_EN
        want = 64'h77;
`else
        want = 64'd5;
`endif
        drive(1'b1, 32'h006281B3, 64'h1004, 1'b1, 1'b0, 1'b1, 5'd5, 64'h77);
        tick();
        checks++;
        if (ex_rs1Data !== want || ex_rs2Data !== 64'd6) begin
            errors++; $display("FAIL bypass_rd5 got %h/%h want %h/6", ex_rs1Data, ex_rs2Data, want);
        end
        drive(1'b1, 32'h006281B3, 64'h1008, 1'b1, 1'b0, 1'b1, 5'd0, 64'h77);
        tick();
        checks++;
        if (ex_rs1Data !== 64'd5) begin
            errors++; $display("FAIL bypass_rd0 got %h want 5", ex_rs1Data);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 32'h00813383, 64'h2000, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        drive(1'b1, 32'h00138433, 64'h2004, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        checks++;
        if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall got %b want 0", id_ready); end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || hazard_count !== 32'd1) begin
            errors++; $display("FAIL lu_bubble got v%b cnt%0d want v0 cnt1", ex_valid, hazard_count);
        end
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %b want 1", id_ready); end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd8 || ex_rs1 !== 5'd7 || hazard_count !== 32'd1 ||
            dut !== m) begin
            errors++; $display("FAIL lu_issue got %h cnt%0d want %h cnt1", dut, hazard_count, m);
        end
    endtask

    task automatic test_imm();
        drive(1'b1, 32'hFE000EE3, 64'h3000, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        checks++;
        if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFFC || ex_regWrite !== 1'b0) begin
            errors++; $display("FAIL imm_beq got %h rw%b want fffffffffffffffc rw0", ex_imm, ex_regWrite);
        end
        drive(1'b1, 32'h800000B7, 64'h3004, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        checks++;
        if (ex_imm !== 64'hFFFF_FFFF_8000_0000 || dut !== m) begin
            errors++; $display("FAIL imm_lui got %h want ffffffff80000000", ex_imm);
        end
    endtask

    task automatic test_backpressure_flush();
        exp_t saved;
        drive(1'b1, 32'h00308213, 64'h4000, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        saved = dut;
        checks++;
        if (saved !== m || saved.valid !== 1'b1) begin
            errors++; $display("FAIL bp_load got %h want %h", saved, m);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h006281B3, 64'h4004 + 64'(i), 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
            checks++;
            if (id_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, id_ready); end
            tick();
            checks++;
            if (dut !== saved) begin errors++; $display("FAIL bp_hold[%0d] got %h want %h", i, dut, saved); end
        end
        drive(1'b1, 32'h006281B3, 64'h4010, 1'b0, 1'b1, 1'b0, 5'd0, 64'h0);
        tick();
        saved.valid = 1'b0;
        checks++;
        if (dut !== saved) begin errors++; $display("FAIL bp_flush got %h want %h", dut, saved); end
    endtask

    task automatic test_flush_loaduse();
        do_reset();
        drive(1'b1, 32'h00813383, 64'h5000, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        drive(1'b1, 32'h00138433, 64'h5004, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0);
        checks++;
        if (id_ready !== 1'b0) begin errors++; $display("FAIL fl_lu_ready got %b want 0", id_ready); end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || hazard_count !== 32'd0) begin
            errors++; $display("FAIL fl_lu_edge got v%b cnt%0d want v0 cnt0", ex_valid, hazard_count);
        end
        drive(1'b1, 32'h00138433, 64'h5004, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        checks++;
        if (ex_valid !== 1'b1 || hazard_count !== 32'd0 || dut !== m) begin
            errors++; $display("FAIL fl_lu_issue got %h cnt%0d want %h cnt0", dut, hazard_count, m);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h00813383, 64'h6000, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
            tick();
            drive(1'b1, 32'h00138433, 64'h6004, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
            tick();
            tick();
        end
        checks++;
        if (ex_valid !== 1'b1 || hazard_count !== 32'd5) begin
            errors++; $display("FAIL ar_pre got v%b cnt%0d want v1 cnt5", ex_valid, hazard_count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || hazard_count !== 32'd0 || dut !== exp_t'(0)) begin
            errors++; $display("FAIL ar_async got %h cnt%0d want 0", dut, hazard_count);
        end
        #1;
        reset = 1'b0;
        m = '0; m_cnt = 0;
        drive(1'b1, 32'h00308213, 64'h6100, 1'b1, 1'b0, 1'b0, 5'd0, 64'h0);
        tick();
        checks++;
        if (ex_valid !== 1'b1 || dut !== m) begin
            errors++; $display("FAIL ar_first_accept got %h want %h", dut, m);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [12];
        logic [31:0] ins;
        logic        exp_rdy;
        ops = '{7'b0000011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                7'b0010011, 7'b0011011, 7'b0110111, 7'b0010111, 7'b0110011, 7'b1110011};
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ((c % 16) == 0)
                for (int r = 0; r < 32; r++) rf[r] = {$urandom, $urandom};
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 11)];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, ins, {$urandom, $urandom},
                  $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), {$urandom, $urandom});
            exp_rdy = ex_ready && !model_lu();
            checks++;
            if (id_ready !== exp_rdy || rs1 !== ins[19:15] || rs2 !== ins[24:20]) begin
                errors++; $display("FAIL rnd_comb[%0d] got rdy%b rs%0d/%0d want rdy%b rs%0d/%0d",
                                   c, id_ready, rs1, rs2, exp_rdy, ins[19:15], ins[24:20]);
            end
            tick();
            checks++;
            if (dut !== m || hazard_count !== m_cnt) begin
                errors++; $display("FAIL rnd_regs[%0d] got %h cnt%0d want %h cnt%0d",
                                   c, dut, hazard_count, m, m_cnt);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 64'(r) | 64'hA5A5_0000_0000_0000;
        rf[0] = 64'hDEAD_BEEF_0000_0001;
        rf[5] = 64'd5;
        rf[6] = 64'd6;
        test_reset();
        test_basic_decode();
        test_wb_bypass();
        test_load_use();
        test_imm();
        test_backpressure_flush();
        test_flush_loaduse();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage sitting between the IF/ID latch and the execute stage. It drives `rs1`/`rs2` into `registerFile`, captures `readData1`/`readData2` plus decoded RV64I fields into the ID/EX pipeline register, and bypasses same-cycle write-back data. It detects load-use hazards and inserts one-cycle bubbles. It honours downstream back-pressure and branch flushes.

## Interface
Parameters:
- `XLEN`, 64, datapath width.
- `CNT_W`, 32, width of the load-use bubble counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_valid`  in  1  IF/ID holds a valid instruction.
- `if_instr`  in  32  instruction word.
- `if_pc`  in  XLEN  instruction PC.
- `id_ready`  out  1  stage accepts `if_*` this cycle (combinational).
- `rs1`, `rs2`  out  5  `if_instr[19:15]`, `[24:20]`; combinational to `registerFile`.
- `readData1`, `readData2`  in  XLEN  register-file read data.
- `wb_regWrite`  in  1  write-back writes this cycle.
- `wb_rd`  in  5  write-back destination.
- `wb_data`  in  XLEN  write-back data.
- `flush`  in  1  taken branch/jump in EX; kill ID/EX contents.
- `ex_ready`  in  1  execute stage accepts ID/EX contents.
- `ex_valid`  out  1  ID/EX holds a valid instruction.
- `ex_pc`  out  XLEN  registered PC.
- `ex_rs1Data`, `ex_rs2Data`  out  XLEN  registered operands.
- `ex_imm`  out  XLEN  sign-extended immediate.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5  register indices.
- `ex_opcode`  out  7  opcode.
- `ex_funct3`  out  3  funct3.
- `ex_funct7`  out  7  funct7.
- `ex_memRead`, `ex_memWrite`, `ex_regWrite`  out  1  control bits.
- `hazard_count`  out  CNT_W  saturating count of load-use bubbles.

## Operation
- **Load-use hazard:** `loaduse = if_valid & ex_valid & ex_memRead & (ex_rd != 0) & (ex_rd == rs1 | ex_rd == rs2)`. The check is conservative: both sources are compared for every format.
- **Upstream ready:** `id_ready = ex_ready & ~loaduse`. It does not depend on `flush`; upstream flushes itself.
- **ID/EX update:** at each posedge, highest priority first:
  1. `flush`: `ex_valid <= 0`. Other fields hold.
  2. `~ex_ready`: all ID/EX fields hold.
  3. `loaduse`: `ex_valid <= 0` (bubble); `hazard_count` increments, saturating at all-ones.
  4. Otherwise: `ex_valid <= if_valid` and all fields load from the current decode.
- **Operand select (per source):**
  - Index 0 selects 0.
  - Otherwise, WB bypass when `wb_regWrite & wb_rd == rsN`.
  - Otherwise `readDataN`.
- **Immediate decode:**
  - I-type (opcodes 0010011, 0011011, 0000011, 1100111): `instr[31:20]`.
  - S-type (0100011): `{[31:25],[11:7]}`.
  - B-type (1100011): `{[31],[7],[30:25],[11:8],0}`.
  - U-type (0110111, 0010111): `{[31:12],12'b0}`.
  - J-type (1101111): `{[31],[19:12],[20],[30:21],0}`.
  - All are sign-extended from bit 31 to XLEN. Any other opcode gives 0.
- **Control decode:**
  - `memRead` = opcode 0000011.
  - `memWrite` = opcode 0100011.
  - `regWrite` = opcode in {0110011, 0111011, 0010011, 0011011, 0000011, 0110111, 0010111, 1101111, 1100111} and `rd != 0`.
- Fields are captured even when `if_valid = 0`. Consumers must qualify them with `ex_valid`.

## Timing
- **Reset:** all registered outputs are 0 asynchronously while `reset` is high, including `ex_valid`, `hazard_count` and every `ex_*` field. `id_ready` then follows `ex_ready`, since `loaduse = 0`.
- **Latency:** one cycle from an accepted `if_*` to the `ex_*` outputs.
- **Load-use:** exactly one bubble per hazard. On the next edge the load leaves ID/EX, so `loaduse` deasserts and the dependent instruction issues. If `ex_ready` is low, the load stays in ID/EX and the stall persists, but no further bubble is counted.
- **`flush` and `loaduse` together:** the edge flushes. The bubble counter does not increment.
- **Reset released mid-stream:** the first accept can happen on the first edge after deassertion.
- **WB bypass** covers only the same-cycle write. Older writes are already in the register file.

## Configuration
- `DECODE_WB_BYPASS_EN` defined: WB bypass as described above.
- `DECODE_WB_BYPASS_EN` undefined: operands are `readDataN` directly, except that x0 is still forced to 0. `wb_*` inputs are unused, and the register file must provide write-through.

## Test plan
- **Reset then decode:** reset, then `if_valid=1`, `ex_ready=1`, instr `add x3,x5,x6` (0x006281B3) with regfile x5=5, x6=6 → next cycle `ex_valid=1`, `ex_rs1Data=5`, `ex_rs2Data=6`, `ex_rd=3`, `ex_regWrite=1`.
- **WB bypass:** same instruction with `wb_regWrite=1`, `wb_rd=5`, `wb_data=0x77` → `ex_rs1Data=0x77`. With `wb_rd=0` → `ex_rs1Data=5`. With the macro undefined → 5 in both cases.
- **Load-use:** `ld x7,8(x2)` followed by `add x8,x7,x1` →
  - `id_ready=0` for one cycle.
  - `ex_valid=0` bubble.
  - The add issues on the following cycle.
  - `hazard_count=1`.
- **Immediate decode:**
  - `beq` with offset -4 (0xFE000EE3) → `ex_imm=0xFFFF_FFFF_FFFF_FFFC`.
  - `lui x1,0x80000` → `ex_imm=0xFFFF_FFFF_8000_0000`.
- **Back-pressure and flush:**
  - Hold `ex_ready=0` for 3 cycles → all `ex_*` outputs are stable and `id_ready=0`.
  - Assert `flush` during the hold → `ex_valid=0` on the next edge.
- **Async reset mid-operation:** assert `reset` between edges while `ex_valid=1` and `hazard_count=5` → both read 0 immediately, before the next clock edge.
